// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, funct codes,
// ALU controls, mux selects and the FSM state type.
package mc_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   localparam logic [1:0] SRC_B_RT     = 2'b00;
   localparam logic [1:0] SRC_B_FOUR   = 2'b01;
   localparam logic [1:0] SRC_B_IMM    = 2'b10;
   localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR,
      EXECUTE, ALU_WB, IMM_EXEC, IMM_WB, BRANCH, JUMP
   } state_t;

   typedef enum logic [1:0] {AOP_ADD, AOP_SUB, AOP_FUNCT, AOP_IMM} alu_op_t;

   // Opcodes that only exist when the extended ISA is enabled.
   function automatic logic is_ext_op(input logic [5:0] op);
      return (op == OP_J) || (op == OP_BNE) || (op == OP_ANDI) ||
             (op == OP_ORI) || (op == OP_SLTI);
   endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Unified-memory handshake between the control unit (master) and memory (slave).
interface mc_control_unit_if;
   logic mem_req;
   logic i_or_d;
   logic mem_write;
   logic mem_ready;

   modport master (output mem_req, output i_or_d, output mem_write, input mem_ready);
   modport slave  (input mem_req, input i_or_d, input mem_write, output mem_ready);
endinterface

// File: rtl/mc_control_unit_alu_decoder.sv
// ALU control decode: maps the operation class plus opcode/funct to an ALU code,
// and flags whether the funct field names a supported R-type operation.
module mc_alu_decoder
   import mc_ctrl_pkg::*;
(
   input  alu_op_t    alu_op,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [2:0] alu_control,
   output logic       funct_valid
);

   logic [2:0] funct_ctrl_s;
   logic [2:0] imm_ctrl_s;

   always_comb begin
      funct_valid  = 1'b1;
      funct_ctrl_s = ALU_ADD;
      case (funct)
         FN_ADD:  funct_ctrl_s = ALU_ADD;
         FN_SUB:  funct_ctrl_s = ALU_SUB;
         FN_AND:  funct_ctrl_s = ALU_AND;
         FN_OR:   funct_ctrl_s = ALU_OR;
         FN_SLT:  funct_ctrl_s = ALU_SLT;
         default: funct_valid  = 1'b0;
      endcase
   end

   always_comb begin
      imm_ctrl_s = ALU_ADD;
      case (opcode)
         OP_ANDI: imm_ctrl_s = ALU_AND;
         OP_ORI:  imm_ctrl_s = ALU_OR;
         OP_SLTI: imm_ctrl_s = ALU_SLT;
         default: imm_ctrl_s = ALU_ADD;
      endcase
   end

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         AOP_SUB:   alu_control = ALU_SUB;
         AOP_FUNCT: alu_control = funct_ctrl_s;
         AOP_IMM:   alu_control = imm_ctrl_s;
         default:   alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM with memory handshake/timeout, jump, BNE,
// logical/compare immediates and illegal-instruction detection.
module mc_control_unit
   import mc_ctrl_pkg::*;
#(
   parameter int EXT_ISA    = 1,
   parameter int WAIT_LIMIT = 16,
   parameter int WAIT_W     = 5
) (
   input  logic               clk,
   input  logic               res,
   mc_control_unit_if.master  mem,
   input  logic [31:0]        instr,
   input  logic               alu_zero,
   output logic               ir_write,
   output logic               pc_en,
   output logic [1:0]         pc_src,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               zero_ext,
   output logic [2:0]         alu_control,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               reg_write,
   output logic               illegal,
   output logic               mem_err
);

   localparam bit              TIMEOUT_EN = (WAIT_LIMIT > 0);
   localparam logic [WAIT_W-1:0] LIMIT_C  = WAIT_LIMIT[WAIT_W-1:0];
   localparam logic [WAIT_W-1:0] CNT_MAX  = {WAIT_W{1'b1}};
   localparam logic [WAIT_W-1:0] CNT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d, decode_next_s;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [5:0]        opcode_s, funct_s;
   alu_op_t           alu_op_s;
   logic [2:0]        alu_ctrl_s;
   logic              funct_valid_s, op_allowed_s, wait_state_s, timeout_s;
   logic              mem_req_s, i_or_d_s, mem_write_s, ir_write_s, pc_en_s;
   logic [1:0]        pc_src_s, src_b_s;
   logic              src_a_s, zero_ext_s, reg_dst_s, mem_to_reg_s, reg_write_s;
   logic              illegal_s, mem_err_s;

   assign opcode_s     = instr[31:26];
   assign funct_s      = instr[5:0];
   assign op_allowed_s = (EXT_ISA != 0) || !is_ext_op(opcode_s);
   assign wait_state_s = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
   // Completion beats timeout: abort only when the limit is hit with no ready.
   assign timeout_s    = TIMEOUT_EN && wait_state_s && !mem.mem_ready && (wait_cnt_q == LIMIT_C);

   mc_alu_decoder u_alu_dec (
      .alu_op      (alu_op_s),
      .opcode      (opcode_s),
      .funct       (funct_s),
      .alu_control (alu_ctrl_s),
      .funct_valid (funct_valid_s)
   );

   always_comb begin
      decode_next_s = FETCH;
      if (op_allowed_s) begin
         case (opcode_s)
            OP_LW, OP_SW:                       decode_next_s = MEM_ADR;
            OP_RTYPE:                           decode_next_s = funct_valid_s ? EXECUTE : FETCH;
            OP_BEQ, OP_BNE:                     decode_next_s = BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  decode_next_s = IMM_EXEC;
            OP_J:                               decode_next_s = JUMP;
            default:                            decode_next_s = FETCH;
         endcase
      end else begin
         decode_next_s = FETCH;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:    state_d = mem.mem_ready ? DECODE : FETCH;
         DECODE:   state_d = decode_next_s;
         MEM_ADR:  state_d = (opcode_s == OP_LW) ? MEM_RD : MEM_WR;
         MEM_RD:   state_d = mem.mem_ready ? MEM_WB : (timeout_s ? FETCH : MEM_RD);
         MEM_WR:   state_d = (mem.mem_ready || timeout_s) ? FETCH : MEM_WR;
         EXECUTE:  state_d = ALU_WB;
         IMM_EXEC: state_d = IMM_WB;
         default:  state_d = FETCH;
      endcase
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if ((state_d != state_q) || timeout_s) begin
         wait_cnt_d = {WAIT_W{1'b0}};
      end else if (wait_state_s && !mem.mem_ready && (wait_cnt_q != CNT_MAX)) begin
         wait_cnt_d = wait_cnt_q + CNT_ONE;
      end else begin
         wait_cnt_d = wait_cnt_q;
      end
   end

   always_comb begin
      case (state_q)
         EXECUTE:  alu_op_s = AOP_FUNCT;
         IMM_EXEC: alu_op_s = AOP_IMM;
         BRANCH:   alu_op_s = AOP_SUB;
         default:  alu_op_s = AOP_ADD;
      endcase
   end

   // Moore decode plus the few strobes qualified by mem_ready/alu_zero/instr.
   always_comb begin
      mem_req_s = 1'b0;  i_or_d_s = 1'b0;  mem_write_s = 1'b0;  ir_write_s = 1'b0;
      pc_en_s = 1'b0;  pc_src_s = PC_SRC_ALU;  src_a_s = 1'b0;  src_b_s = SRC_B_RT;
      zero_ext_s = 1'b0;  reg_dst_s = 1'b0;  mem_to_reg_s = 1'b0;  reg_write_s = 1'b0;
      illegal_s = 1'b0;  mem_err_s = 1'b0;
      case (state_q)
         FETCH: begin
            mem_req_s  = !timeout_s;
            src_b_s    = SRC_B_FOUR;
            ir_write_s = mem.mem_ready;
            pc_en_s    = mem.mem_ready;
            mem_err_s  = timeout_s;
         end
         DECODE: begin
            src_b_s   = SRC_B_IMM_SH;
            illegal_s = (decode_next_s == FETCH);
         end
         MEM_ADR: begin
            src_a_s = 1'b1;
            src_b_s = SRC_B_IMM;
         end
         MEM_RD: begin
            mem_req_s = !timeout_s;
            i_or_d_s  = 1'b1;
            mem_err_s = timeout_s;
         end
         MEM_WB: begin
            mem_to_reg_s = 1'b1;
            reg_write_s  = 1'b1;
         end
         MEM_WR: begin
            mem_req_s   = !timeout_s;
            mem_write_s = !timeout_s;
            i_or_d_s    = 1'b1;
            mem_err_s   = timeout_s;
         end
         EXECUTE:  src_a_s = 1'b1;
         ALU_WB: begin
            reg_dst_s   = 1'b1;
            reg_write_s = 1'b1;
         end
         IMM_EXEC: begin
            src_a_s    = 1'b1;
            src_b_s    = SRC_B_IMM;
            zero_ext_s = (opcode_s == OP_ANDI) || (opcode_s == OP_ORI);
         end
         IMM_WB:   reg_write_s = 1'b1;
         BRANCH: begin
            src_a_s  = 1'b1;
            pc_src_s = PC_SRC_ALUOUT;
            pc_en_s  = (opcode_s == OP_BNE) ? !alu_zero : alu_zero;
         end
         JUMP: begin
            pc_src_s = PC_SRC_JUMP;
            pc_en_s  = 1'b1;
         end
         default: mem_req_s = 1'b0;
      endcase
   end

   // State and wait counter; reset returns to FETCH with an empty counter.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q    <= FETCH;
         wait_cnt_q <= {WAIT_W{1'b0}};
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Gating with res makes an in-flight access drop the instant reset asserts.
   assign mem.mem_req   = res & mem_req_s;
   assign mem.i_or_d    = res & i_or_d_s;
   assign mem.mem_write = res & mem_write_s;
   assign ir_write      = res & ir_write_s;
   assign pc_en         = res & pc_en_s;
   assign pc_src        = res ? pc_src_s : PC_SRC_ALU;
   assign alu_src_a     = res & src_a_s;
   assign alu_src_b     = res ? src_b_s : SRC_B_RT;
   assign zero_ext      = res & zero_ext_s;
   assign alu_control   = res ? alu_ctrl_s : ALU_ADD;
   assign reg_dst       = res & reg_dst_s;
   assign mem_to_reg    = res & mem_to_reg_s;
   assign reg_write     = res & reg_write_s;
   assign illegal       = res & illegal_s;
   assign mem_err       = res & mem_err_s;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench: dut_a uses the full ISA with the default timeout,
// dut_b has EXT_ISA=0 and WAIT_LIMIT=4.
module tb_mc_control_unit;
   import mc_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        res;
   logic        alu_zero;
   logic [31:0] instr, instr_b;
   int          n_run = 0;
   int          n_fail = 0;

   mc_control_unit_if if_a ();
   mc_control_unit_if if_b ();

   logic       a_ir_write, a_pc_en, a_src_a, a_zero_ext, a_reg_dst, a_mem_to_reg, a_reg_write, a_illegal, a_mem_err;
   logic [1:0] a_pc_src, a_src_b;
   logic [2:0] a_alu_ctrl;
   logic       b_ir_write, b_pc_en, b_src_a, b_zero_ext, b_reg_dst, b_mem_to_reg, b_reg_write, b_illegal, b_mem_err;
   logic [1:0] b_pc_src, b_src_b;
   logic [2:0] b_alu_ctrl;

   mc_control_unit #(.EXT_ISA(1), .WAIT_LIMIT(16), .WAIT_W(5)) dut_a (
      .clk(clk), .res(res), .mem(if_a), .instr(instr), .alu_zero(alu_zero),
      .ir_write(a_ir_write), .pc_en(a_pc_en), .pc_src(a_pc_src), .alu_src_a(a_src_a),
      .alu_src_b(a_src_b), .zero_ext(a_zero_ext), .alu_control(a_alu_ctrl), .reg_dst(a_reg_dst),
      .mem_to_reg(a_mem_to_reg), .reg_write(a_reg_write), .illegal(a_illegal), .mem_err(a_mem_err)
   );

   mc_control_unit #(.EXT_ISA(0), .WAIT_LIMIT(4), .WAIT_W(3)) dut_b (
      .clk(clk), .res(res), .mem(if_b), .instr(instr_b), .alu_zero(alu_zero),
      .ir_write(b_ir_write), .pc_en(b_pc_en), .pc_src(b_pc_src), .alu_src_a(b_src_a),
      .alu_src_b(b_src_b), .zero_ext(b_zero_ext), .alu_control(b_alu_ctrl), .reg_dst(b_reg_dst),
      .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write), .illegal(b_illegal), .mem_err(b_mem_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      res = 1'b0; alu_zero = 1'b0; instr = 32'h0; instr_b = 32'h0;
      if_a.mem_ready = 1'b0; if_b.mem_ready = 1'b0;
      #1;
      chk("rst_state", dut_a.state_q, FETCH);
      chk("rst_mem_req", if_a.mem_req, 1'b0);
      chk("rst_src_b", a_src_b, 2'b00);
      chk("rst_alu_ctrl", a_alu_ctrl, 3'b010);
      chk("rst_b_mem_req", if_b.mem_req, 1'b0);
      tick(); tick();
      res = 1'b1; #1;
      chk("fetch_mem_req", if_a.mem_req, 1'b1);
      chk("fetch_src_b", a_src_b, 2'b01);
      chk("fetch_wait_irw", a_ir_write, 1'b0);
      chk("fetch_wait_pcen", a_pc_en, 1'b0);
      tick();
      chk("fetch_hold", dut_a.state_q, FETCH);

      // add $3,$1,$2
      instr = 32'h0022_1820; if_a.mem_ready = 1'b1; #1;
      chk("t1_fetch_irw", a_ir_write, 1'b1);
      chk("t1_fetch_pcen", a_pc_en, 1'b1);
      tick();
      chk("t1_decode", dut_a.state_q, DECODE);
      chk("t1_dec_src_b", a_src_b, 2'b11);
      chk("t1_dec_illegal", a_illegal, 1'b0);
      tick();
      chk("t1_execute", dut_a.state_q, EXECUTE);
      chk("t1_ex_alu", a_alu_ctrl, 3'b010);
      chk("t1_ex_src_a", a_src_a, 1'b1);
      chk("t1_ex_regw", a_reg_write, 1'b0);
      tick();
      chk("t1_alu_wb", dut_a.state_q, ALU_WB);
      chk("t1_wb_regw", a_reg_write, 1'b1);
      chk("t1_wb_regdst", a_reg_dst, 1'b1);
      tick();
      chk("t1_back_fetch", dut_a.state_q, FETCH);
      chk("t1_fetch_regw", a_reg_write, 1'b0);

      // sub: funct 100010
      instr = 32'h0022_1822;
      tick(); tick();
      chk("sub_ex_alu", a_alu_ctrl, 3'b110);
      tick(); tick();

      // lw with three wait cycles in MEM_RD
      instr = 32'h8C22_0004;
      tick();
      chk("t2_decode", dut_a.state_q, DECODE);
      tick();
      chk("t2_mem_adr", dut_a.state_q, MEM_ADR);
      chk("t2_adr_src_b", a_src_b, 2'b10);
      chk("t2_adr_src_a", a_src_a, 1'b1);
      tick();
      for (int i = 0; i < 4; i++) begin
         if_a.mem_ready = (i == 3); #1;
         chk("t2_mem_rd", dut_a.state_q, MEM_RD);
         chk("t2_rd_req", if_a.mem_req, 1'b1);
         chk("t2_rd_iord", if_a.i_or_d, 1'b1);
         tick();
      end
      chk("t2_mem_wb", dut_a.state_q, MEM_WB);
      chk("t2_wb_m2r", a_mem_to_reg, 1'b1);
      chk("t2_wb_regw", a_reg_write, 1'b1);
      chk("t2_wb_regdst", a_reg_dst, 1'b0);
      tick();
      chk("t2_fetch", dut_a.state_q, FETCH);

      // andi then slti
      instr = 32'h3022_0005;
      tick(); tick();
      chk("andi_imm_exec", dut_a.state_q, IMM_EXEC);
      chk("andi_alu", a_alu_ctrl, 3'b000);
      chk("andi_zext", a_zero_ext, 1'b1);
      chk("andi_src_b", a_src_b, 2'b10);
      tick();
      chk("andi_wb_regw", a_reg_write, 1'b1);
      chk("andi_wb_regdst", a_reg_dst, 1'b0);
      tick();
      instr = 32'h2822_0005;
      tick(); tick();
      chk("slti_alu", a_alu_ctrl, 3'b111);
      chk("slti_zext", a_zero_ext, 1'b0);
      tick(); tick();

      // bne then beq, both zero-flag polarities
      instr = 32'h1422_0001;
      tick(); tick();
      alu_zero = 1'b1; #1;
      chk("bne_z1_pcen", a_pc_en, 1'b0);
      chk("bne_alu", a_alu_ctrl, 3'b110);
      alu_zero = 1'b0; #1;
      chk("bne_z0_pcen", a_pc_en, 1'b1);
      chk("bne_pc_src", a_pc_src, 2'b01);
      tick();
      chk("bne_fetch", dut_a.state_q, FETCH);
      instr = 32'h1022_0001;
      tick(); tick();
      alu_zero = 1'b1; #1;
      chk("beq_z1_pcen", a_pc_en, 1'b1);
      alu_zero = 1'b0; #1;
      chk("beq_z0_pcen", a_pc_en, 1'b0);
      tick();

      // j
      instr = 32'h0800_0010;
      tick(); tick();
      chk("j_state", dut_a.state_q, JUMP);
      chk("j_pc_src", a_pc_src, 2'b10);
      chk("j_pcen", a_pc_en, 1'b1);
      tick();
      chk("j_fetch", dut_a.state_q, FETCH);

      // illegal opcode and bad funct
      instr = 32'hFC00_0000;
      tick();
      chk("ill_op_pulse", a_illegal, 1'b1);
      chk("ill_op_regw", a_reg_write, 1'b0);
      tick();
      chk("ill_op_fetch", dut_a.state_q, FETCH);
      chk("ill_op_clear", a_illegal, 1'b0);
      instr = 32'h0022_183F;
      tick();
      chk("ill_fn_pulse", a_illegal, 1'b1);
      tick();
      chk("ill_fn_fetch", dut_a.state_q, FETCH);
      chk("ill_fn_regw", a_reg_write, 1'b0);

      // reset in the middle of a lw read
      instr = 32'h8C22_0004;
      tick(); tick();
      if_a.mem_ready = 1'b0;
      tick();
      chk("mid_rd_req", if_a.mem_req, 1'b1);
      res = 1'b0; #1;
      chk("mid_rst_req", if_a.mem_req, 1'b0);
      chk("mid_rst_iord", if_a.i_or_d, 1'b0);
      chk("mid_rst_state", dut_a.state_q, FETCH);
      tick();
      res = 1'b1; #1;
      chk("post_rst_state", dut_a.state_q, FETCH);
      chk("post_rst_req", if_a.mem_req, 1'b1);
      chk("post_rst_irw", a_ir_write, 1'b0);

      // dut_b: j is illegal without the extended ISA
      instr_b = 32'h0800_0010; if_b.mem_ready = 1'b1; #1;
      chk("b_fetch_irw", b_ir_write, 1'b1);
      tick();
      chk("b_j_illegal", b_illegal, 1'b1);
      if_b.mem_ready = 1'b0;
      tick();
      chk("b_j_fetch", dut_b.state_q, FETCH);
      chk("b_j_ill_clear", b_illegal, 1'b0);

      // dut_b: sw with memory never ready times out after 4 wait cycles
      instr_b = 32'hAC22_0004; if_b.mem_ready = 1'b1;
      tick();
      if_b.mem_ready = 1'b0;
      tick(); tick();
      for (int k = 0; k < 4; k++) begin
         chk("to_state", dut_b.state_q, MEM_WR);
         chk("to_write", if_b.mem_write, 1'b1);
         chk("to_no_err", b_mem_err, 1'b0);
         tick();
      end
      chk("to_err", b_mem_err, 1'b1);
      chk("to_req_drop", if_b.mem_req, 1'b0);
      chk("to_write_drop", if_b.mem_write, 1'b0);
      tick();
      chk("to_fetch", dut_b.state_q, FETCH);
      chk("to_err_clear", b_mem_err, 1'b0);

      // dut_b: ready arriving exactly at the limit completes the fetch
      tick(); tick(); tick(); tick();
      instr_b = 32'hFC00_0000; if_b.mem_ready = 1'b1; #1;
      chk("lim_irw", b_ir_write, 1'b1);
      chk("lim_no_err", b_mem_err, 1'b0);
      tick();
      chk("lim_decode", dut_b.state_q, DECODE);
      if_b.mem_ready = 1'b0;
      tick();

      // dut_b: aborted fetch stays in FETCH without loading IR or PC
      tick(); tick(); tick(); tick();
      chk("fto_err", b_mem_err, 1'b1);
      chk("fto_irw", b_ir_write, 1'b0);
      chk("fto_pcen", b_pc_en, 1'b0);
      chk("fto_req", if_b.mem_req, 1'b0);
      tick();
      chk("fto_state", dut_b.state_q, FETCH);
      chk("fto_req_back", if_b.mem_req, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
